// File: rtl/serial_divider_pkg.sv
// Shared definitions for the serial restoring divider: FSM state encoding and default width.
package serial_divider_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_divider_full_sub.sv
// One-bit full subtractor cell; chained to form the divider's trial-subtract borrow ripple.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_divider.sv
// Serial restoring unsigned divider, one quotient bit per cycle, done after N+1 cycles.
// Optional div_zero flag output is enabled by defining DIV_ZERO_FLAG_EN.
module serial_divider
    import serial_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
`ifdef DIV_ZERO_FLAG_EN
    output logic         div_zero,
`endif
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N + 1);

    state_e         state_r, state_nx_s;
    logic [CW-1:0]  count_r, count_nx_s;
    logic [N-1:0]   rem_r, rem_nx_s;
    logic [N-1:0]   quo_r, quo_nx_s;
    logic [N-1:0]   divisor_r, divisor_nx_s;
    logic           busy_r;
    logic           done_r;

    logic [N:0]     shifted_s;
    logic [N:0]     sub_b_s;
    logic [N:0]     diff_s;
    logic [N+1:0]   borrow_s;

    // The quotient register doubles as the dividend shift register: its MSB feeds the remainder.
    assign shifted_s   = {rem_r, quo_r[N-1]};
    assign sub_b_s     = {1'b0, divisor_r};
    assign borrow_s[0] = 1'b0;

    for (genvar i = 0; i <= N; i++) begin : g_sub_chain
        full_sub u_full_sub (
            .a          (shifted_s[i]),
            .b          (sub_b_s[i]),
            .borrow_in  (borrow_s[i]),
            .diff       (diff_s[i]),
            .borrow_out (borrow_s[i+1])
        );
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_nx_s   = state_r;
        count_nx_s   = count_r;
        rem_nx_s     = rem_r;
        quo_nx_s     = quo_r;
        divisor_nx_s = divisor_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s   = BUSY;
                    count_nx_s   = CW'(N);
                    rem_nx_s     = {N{1'b0}};
                    quo_nx_s     = dividend;
                    divisor_nx_s = divisor;
                end else begin
                    state_nx_s   = IDLE;
                end
            end
            BUSY: begin
                // A borrow out of the top cell means the divisor did not fit: restore.
                if (borrow_s[N+1]) begin
                    rem_nx_s = shifted_s[N-1:0];
                    quo_nx_s = {quo_r[N-2:0], 1'b0};
                end else begin
                    rem_nx_s = diff_s[N-1:0];
                    quo_nx_s = {quo_r[N-2:0], 1'b1};
                end
                count_nx_s = count_r - CW'(1);
                if (count_r == CW'(1)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r   <= IDLE;
            count_r   <= {CW{1'b0}};
            rem_r     <= {N{1'b0}};
            quo_r     <= {N{1'b0}};
            divisor_r <= {N{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            count_r   <= count_nx_s;
            rem_r     <= rem_nx_s;
            quo_r     <= quo_nx_s;
            divisor_r <= divisor_nx_s;
            busy_r    <= (state_nx_s != IDLE);
            done_r    <= (state_nx_s == DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

`ifdef DIV_ZERO_FLAG_EN
    logic div_zero_r;

    // Flag is cleared when a division starts and published alongside the results.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_zero_r <= 1'b0;
        end else if (state_r == IDLE && start) begin
            div_zero_r <= 1'b0;
        end else if (state_r == BUSY && state_nx_s == DONE) begin
            div_zero_r <= (divisor_r == {N{1'b0}});
        end else begin
            div_zero_r <= div_zero_r;
        end
    end

    assign div_zero = div_zero_r;
`endif

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: arithmetic reference model for N=4 plus directed N=8 case.
module tb_serial_divider;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       start4, start8;
    logic [3:0] dividend4, divisor4, quotient4, remainder4;
    logic [7:0] dividend8, divisor8, quotient8, remainder8;
    logic       busy4, done4, busy8, done8;
    logic       dz4, dz8;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    serial_divider #(.N(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .start(start4),
        .dividend(dividend4), .divisor(divisor4),
        .busy(busy4), .done(done4),
`ifdef DIV_ZERO_FLAG_EN
        .div_zero(dz4),
`endif
        .quotient(quotient4), .remainder(remainder4)
    );

    serial_divider #(.N(8)) dut8 (
        .Clock(Clock), .Reset(Reset), .start(start8),
        .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8),
`ifdef DIV_ZERO_FLAG_EN
        .div_zero(dz8),
`endif
        .quotient(quotient8), .remainder(remainder8)
    );

`ifndef DIV_ZERO_FLAG_EN
    assign dz4 = 1'b0;
    assign dz8 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 dividing, 2 result cycle.
    int         m_phase = 0;
    int         m_cnt   = 0;
    logic [3:0] m_q = 4'd0, m_r = 4'd0, m_pq = 4'd0, m_pr = 4'd0;
    logic       m_dz = 1'b0, m_pdz = 1'b0, m_valid = 1'b1;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_q     <= 4'd0;
            m_r     <= 4'd0;
            m_dz    <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            case (m_phase)
                0: if (start4) begin
                    m_phase <= 1;
                    m_cnt   <= 4;
                    m_pq    <= (divisor4 == 4'd0) ? 4'd15 : dividend4 / divisor4;
                    m_pr    <= (divisor4 == 4'd0) ? dividend4 : dividend4 % divisor4;
                    m_pdz   <= (divisor4 == 4'd0);
                    m_dz    <= 1'b0;
                    m_valid <= 1'b0;
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_phase <= 2;
                        m_q     <= m_pq;
                        m_r     <= m_pr;
                        m_dz    <= m_pdz;
                        m_valid <= 1'b1;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        chk("busy", {31'd0, busy4}, {31'd0, (m_phase != 0)});
        chk("done", {31'd0, done4}, {31'd0, (m_phase == 2)});
        if (m_valid) begin
            chk("quotient", {28'd0, quotient4}, {28'd0, m_q});
            chk("remainder", {28'd0, remainder4}, {28'd0, m_r});
        end
`ifdef DIV_ZERO_FLAG_EN
        chk("div_zero", {31'd0, dz4}, {31'd0, m_dz});
`endif
    end

    task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                          input int eq, input int er, input int edz);
        int lat;
        @(posedge Clock); #1;
        start4 = 1'b1; dividend4 = a; divisor4 = b;
        @(posedge Clock); #1;
        start4 = 1'b0;
        dividend4 = 4'd11; divisor4 = 4'd5;
        lat = 1;
        while (!done4 && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
        end
        chk("latency", lat, 5);
        chk("lit_quotient", {28'd0, quotient4}, eq);
        chk("lit_remainder", {28'd0, remainder4}, er);
`ifdef DIV_ZERO_FLAG_EN
        chk("lit_div_zero", {31'd0, dz4}, edz);
`else
        if (edz > 1) chk("edz_range", edz, 1);
`endif
    endtask

    initial begin
        int ndone;
        int lat;
        Reset = 1'b1;
        start4 = 1'b0; dividend4 = 4'd0; divisor4 = 4'd0;
        start8 = 1'b0; dividend8 = 8'd0; divisor8 = 8'd0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_busy", {31'd0, busy4}, 0);
        chk("rst_done", {31'd0, done4}, 0);
        chk("rst_quotient", {28'd0, quotient4}, 0);
        chk("rst_remainder", {28'd0, remainder4}, 0);
        Reset = 1'b0;

        do_div(4'd13, 4'd4, 3, 1, 0);
        do_div(4'd15, 4'd1, 15, 0, 0);
        do_div(4'd3, 4'd9, 0, 3, 0);
        do_div(4'd7, 4'd0, 15, 7, 1);

        // Start held for ten edges; inputs disturbed mid-division.
        @(posedge Clock); #1;
        start4 = 1'b1; dividend4 = 4'd13; divisor4 = 4'd4;
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge Clock); #1;
            if (c == 2) begin dividend4 = 4'd9; divisor4 = 4'd2; end
            if (c == 5) begin dividend4 = 4'd13; divisor4 = 4'd4; end
            if (c == 10) start4 = 1'b0;
            if (done4) begin
                ndone++;
                chk("held_quotient", {28'd0, quotient4}, 3);
                chk("held_remainder", {28'd0, remainder4}, 1);
            end
        end
        chk("held_done_count", ndone, 2);

        // Reset in the second BUSY cycle.
        @(posedge Clock); #1;
        start4 = 1'b1; dividend4 = 4'd13; divisor4 = 4'd4;
        @(posedge Clock); #1;
        start4 = 1'b0;
        @(posedge Clock); #2;
        Reset = 1'b1;
        #1;
        chk("async_quotient", {28'd0, quotient4}, 0);
        chk("async_remainder", {28'd0, remainder4}, 0);
        chk("async_busy", {31'd0, busy4}, 0);
        chk("async_done", {31'd0, done4}, 0);
        @(posedge Clock); @(posedge Clock); #1;
        Reset = 1'b0;
        do_div(4'd9, 4'd2, 4, 1, 0);

        // Wider instance.
        @(posedge Clock); #1;
        start8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd7;
        @(posedge Clock); #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 30) begin
            @(posedge Clock); #1;
            lat++;
        end
        chk("n8_latency", lat, 9);
        chk("n8_quotient", {24'd0, quotient8}, 28);
        chk("n8_remainder", {24'd0, remainder8}, 4);
        chk("n8_div_zero", {31'd0, dz8}, 0);
        @(posedge Clock); #1;
        chk("n8_idle_busy", {31'd0, busy8}, 0);

        repeat (2) @(posedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
